// File: rtl/xor_serial_sched_pkg.sv
// Shared types and helpers for the bit-serial XOR scheduler.
package xor_serial_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Index width that never collapses to zero bits.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick_n.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping mod N.
module rr_pick_n
    import xor_serial_sched_pkg::*;
#(
    parameter  int N   = 4,
    localparam int IDW = clog2_min1(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] index,
    output logic           any
);

    always_comb begin
        int   j;
        logic found;
        grant = '0;
        index = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                index    = IDW'(j);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/xor_serial_sched.sv
// Round-robin shared 1-bit XOR datapath: arbitrates N operand pairs and streams them LSB-first.
//
// state   | meaning
// S_IDLE  | arbitrating; gnt follows the picker, winner's operands captured at the edge
// S_SHIFT | one operand bit per cycle through the xor gate, W cycles
// S_DONE  | result/done/done_id presented for one cycle, then back to IDLE
module xor_serial_sched
    import xor_serial_sched_pkg::*;
#(
    parameter  int N   = 4,
    parameter  int W   = 8,
    localparam int IDW = clog2_min1(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] op_a,
    input  logic [N*W-1:0] op_b,
    output logic [N-1:0]   gnt,
    output logic           busy,
    output logic           done,
    output logic [IDW-1:0] done_id,
    output logic [W-1:0]   result
);

    localparam int CW = clog2_min1(W);

    state_t         state;
    logic [W-1:0]   sa, sb, acc, acc_next;
    logic [CW-1:0]  cnt;
    logic [IDW-1:0] id, ptr, pick_idx;
    logic [N-1:0]   pick_gnt;
    logic           pick_any;
    logic           y;

    rr_pick_n #(.N(N)) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (pick_gnt),
        .index (pick_idx),
        .any   (pick_any)
    );

    xor u_xor (y, sa[0], sb[0]);

    // New bit enters at the MSB so the LSB-first stream lands in order after W shifts.
    assign acc_next = (acc >> 1) | (W'(y) << (W - 1));

    assign gnt  = (state == S_IDLE) ? pick_gnt : '0;
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            sa      <= '0;
            sb      <= '0;
            acc     <= '0;
            cnt     <= '0;
            id      <= '0;
            ptr     <= '0;
            done    <= 1'b0;
            done_id <= '0;
            result  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (pick_any) begin
                        sa    <= op_a[pick_idx*W +: W];
                        sb    <= op_b[pick_idx*W +: W];
                        id    <= pick_idx;
                        cnt   <= '0;
                        acc   <= '0;
                        ptr   <= (pick_idx == IDW'(N - 1)) ? '0 : pick_idx + 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        result  <= acc_next;
                        done    <= 1'b1;
                        done_id <= id;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xor_serial_sched.sv
// Bench for xor_serial_sched: job-timeline reference model plus directed and random stimulus.
module tb_xor_serial_sched;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] op_a = '0;
    logic [N*W-1:0] op_b = '0;
    logic [N-1:0]   gnt;
    logic           busy;
    logic           done;
    logic [IDW-1:0] done_id;
    logic [W-1:0]   result;

    xor_serial_sched #(.N(N), .W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req),
        .op_a    (op_a),
        .op_b    (op_b),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .result  (result)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: a job granted in cycle g is busy in (g, g+W+1], done in g+W+1.
    int           cyc = 0;
    bit           m_active = 0;
    int           m_g = 0;
    int           m_ptr = 0;
    logic [W-1:0] m_pend = '0;
    int           m_pid = 0;
    logic [W-1:0] m_result = '0;
    int           m_done_id = 0;

    int             gnt_log[$];
    int             gnt_cyc[$];
    logic [N-1:0]   obs_gnt;
    logic [W-1:0]   last_res;
    int             last_id;
    int             last_done_cyc = -1;

    task automatic cycle(input logic [N-1:0] r, input logic [N*W-1:0] a, input logic [N*W-1:0] b);
        logic [N-1:0] exp_gnt;
        bit           exp_busy;
        bit           exp_done;
        int           w;
        @(negedge clk);
        req  = r;
        op_a = a;
        op_b = b;
        #1;
        if (m_active && cyc > m_g + W + 1) m_active = 0;
        exp_busy = m_active && (cyc > m_g);
        exp_done = m_active && (cyc == m_g + W + 1);
        if (exp_done) begin
            m_result  = m_pend;
            m_done_id = m_pid;
        end
        exp_gnt = '0;
        if (!m_active) begin
            w = -1;
            for (int k = 0; k < N; k++)
                if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            if (w >= 0) begin
                exp_gnt[w] = 1'b1;
                m_active   = 1;
                m_g        = cyc;
                m_pend     = a[w*W +: W] ^ b[w*W +: W];
                m_pid      = w;
                m_ptr      = (w + 1) % N;
            end
        end
        chk("gnt", gnt, exp_gnt);
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("result", result, m_result);
        if (exp_done) chk("done_id", done_id, m_done_id);
        obs_gnt = gnt;
        if (gnt != '0) begin
            for (int k = 0; k < N; k++)
                if (gnt[k]) gnt_log.push_back(k);
            gnt_cyc.push_back(cyc);
        end
        if (done) begin
            last_res      = result;
            last_id       = int'(done_id);
            last_done_cyc = cyc;
        end
        cyc++;
    endtask

    // Called right after cycle(), before the next rising edge.
    task automatic reset_now(input int hold);
        req = '0;
        #1;
        rst_n = 1'b0;
        #1;
        m_active = 0;
        m_ptr    = 0;
        m_result = '0;
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_done_id", done_id, 0);
        repeat (hold) @(negedge clk);
        rst_n = 1'b1;
    endtask

    function automatic logic [N*W-1:0] rnd();
        return N*W'($urandom);
    endfunction

    initial begin
        int           g;
        logic [W-1:0] want;
        logic [N*W-1:0] a, b;

        #3;
        chk("por_gnt", gnt, 0);
        chk("por_busy", busy, 0);
        chk("por_done", done, 0);
        chk("por_result", result, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Single job on requester 2.
        cycle(4'b0100, 32'h00A5_0000, 32'h000F_0000);
        g = cyc - 1;
        chk("single_gnt", obs_gnt, 4'b0100);
        repeat (W + 1) cycle('0, rnd(), rnd());
        chk("single_done_cycle", last_done_cyc, g + W + 1);
        chk("single_result", last_res, 8'hAA);
        chk("single_id", last_id, 2);

        // Pointer wrap: ptr is 3 here, so order is 3, 0, 3.
        gnt_log.delete();
        repeat (3 * (W + 2)) cycle(4'b1001, rnd(), rnd());
        chk("wrap_count", gnt_log.size(), 3);
        if (gnt_log.size() == 3) begin
            chk("wrap_first", gnt_log[0], 3);
            chk("wrap_second", gnt_log[1], 0);
            chk("wrap_third", gnt_log[2], 3);
        end

        // Operand/request noise while shifting must not disturb the job.
        cycle(4'b0001, 32'h0000_00FF, 32'h0000_0000);
        g = cyc - 1;
        chk("noise_gnt", obs_gnt, 4'b0001);
        repeat (W) cycle(4'b1110, rnd(), rnd());
        cycle('0, rnd(), rnd());
        chk("noise_done_cycle", last_done_cyc, g + W + 1);
        chk("noise_result", last_res, 8'hFF);

        // Abort mid-job, then a fresh job on requester 1.
        cycle(4'b0010, rnd(), rnd());
        g = last_done_cyc;
        repeat (3) cycle('0, rnd(), rnd());
        reset_now(2);
        repeat (W + 3) cycle('0, rnd(), rnd());
        chk("abort_no_done", last_done_cyc, g);
        a = rnd();
        b = rnd();
        want = a[15:8] ^ b[15:8];
        cycle(4'b0010, a, b);
        chk("abort_next_gnt", obs_gnt, 4'b0010);
        repeat (W + 1) cycle('0, rnd(), rnd());
        chk("abort_next_result", last_res, want);
        chk("abort_next_id", last_id, 1);

        // After reset with all requests held: 0,1,2,3,0 at W+2 spacing.
        repeat (2) cycle('0, rnd(), rnd());
        reset_now(1);
        gnt_log.delete();
        gnt_cyc.delete();
        cycle(4'b1111, rnd(), rnd());
        chk("rr_first_gnt", obs_gnt, 4'b0001);
        repeat (5 * (W + 2) - 1) cycle(4'b1111, rnd(), rnd());
        chk("rr_count", gnt_log.size(), 5);
        if (gnt_log.size() == 5) begin
            for (int i = 0; i < 5; i++) chk("rr_order", gnt_log[i], i % N);
            for (int i = 1; i < 5; i++) chk("rr_spacing", gnt_cyc[i] - gnt_cyc[i-1], W + 2);
        end

        // Random traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            cycle(N'($urandom) & N'($urandom), rnd(), rnd());
            if ($urandom_range(0, 199) == 0) reset_now(1);
        end
        repeat (W + 2) cycle('0, rnd(), rnd());

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
